fetch_stage: RTL and testbench

Instruction fetch stage of the 3-stage RISC-V CPU. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It holds the returned instruction in a fetch register, and presents the instruction, its PC and its opcode field to the downstream decode/instruction-type lookup. It honours downstream stall and execute-stage redirects (branch/jump).

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// and holds each returned instruction until decode accepts it.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode,
  output logic            fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] r_if_pc;
  logic            r_if_valid;
  logic            r_fetch_err;

  // Redirect outranks both ack and stall, whatever the current state.
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    if (r_state == S_FETCH) begin
      imem_req = 1'b1;
    end
    if (redirect_valid) begin
      w_next_state = S_FETCH;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_FETCH;
        S_FETCH: if (imem_ack) w_next_state = S_VALID;
        S_VALID: if (!stall) w_next_state = S_FETCH;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_if_instr  <= '0;
      r_if_pc     <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (redirect_valid) begin
        r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
        r_if_valid <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          r_fetch_err <= 1'b1;
        end
      end else if (r_state == S_FETCH && imem_ack) begin
        r_if_instr <= imem_rdata;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
        r_pc       <= r_pc + XLEN'(4);
      end else if (r_state == S_VALID && !stall) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign if_opcode = r_if_instr[6:0];
  assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed handshake/stall/redirect scenarios, a random
// transaction phase against a transaction-level PC model, and a wrap-around instance.
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_ack, stall, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, if_valid, fetch_err;
  logic [31:0] imem_addr, if_instr, if_pc;
  logic [6:0]  if_opcode;

  logic        rst2N, ack2, stall2, redirValid2;
  logic [31:0] rdata2, redirPc2;
  logic        req2, valid2, err2;
  logic [31:0] addr2, instr2, ifPc2;
  logic [6:0]  opcode2;

  int          errors = 0;
  int          checks = 0;

  logic [31:0] expPc, lastPc, lastInstr;
  logic        expErr;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode),
    .fetch_err(fetch_err)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(rst2N),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .stall(stall2), .redirect_valid(redirValid2), .redirect_pc(redirPc2),
    .if_valid(valid2), .if_instr(instr2), .if_pc(ifPc2), .if_opcode(opcode2),
    .fetch_err(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic stl,
                               input logic rv, input logic [31:0] rpc);
    imem_ack       = ack;
    imem_rdata     = data;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected view while a request is outstanding.
  task automatic checkFetching(input string tag);
    checkOutput({tag, ".req"},   32'(imem_req), 32'd1);
    checkOutput({tag, ".addr"},  imem_addr, expPc);
    checkOutput({tag, ".valid"}, 32'(if_valid), 32'd0);
    checkOutput({tag, ".ifpc"},  if_pc, lastPc);
    checkOutput({tag, ".err"},   32'(fetch_err), 32'(expErr));
  endtask

  // Expected view while an instruction is presented to decode.
  task automatic checkHeld(input string tag);
    checkOutput({tag, ".req"},    32'(imem_req), 32'd0);
    checkOutput({tag, ".valid"},  32'(if_valid), 32'd1);
    checkOutput({tag, ".ifpc"},   if_pc, lastPc);
    checkOutput({tag, ".instr"},  if_instr, lastInstr);
    checkOutput({tag, ".opcode"}, 32'(if_opcode), 32'(lastInstr[6:0]));
    checkOutput({tag, ".err"},    32'(fetch_err), 32'(expErr));
  endtask

  task automatic doFetch(input int lat, input logic [31:0] data, input int stallCyc,
                         input logic redirInValid);
    logic [31:0] tgt;
    for (int i = 0; i < lat; i++) begin
      checkFetching("wait");
      applyStimulus(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    checkFetching("ack");
    applyStimulus(1'b1, data, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    lastPc    = expPc;
    expPc     = expPc + 32'd4;
    lastInstr = data;
    for (int i = 0; i < stallCyc; i++) begin
      checkHeld("stall");
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 32'h0);
    end
    checkHeld("consume");
    if (redirInValid) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      applyStimulus(1'b0, $urandom, 1'b1, 1'b1, tgt);
      expPc = tgt;
    end else begin
      applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    end
    checkFetching("next");
  endtask

  task automatic doRedirect(input int waitCyc, input logic withAck, input logic [31:0] tgt);
    for (int i = 0; i < waitCyc; i++) begin
      checkFetching("rwait");
      applyStimulus(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    end
    checkFetching("rpre");
    applyStimulus(withAck, $urandom, 1'b0, 1'b1, tgt);
    expPc = tgt & 32'hFFFF_FFFC;
    if (tgt[1:0] != 2'b00) expErr = 1'b1;
    checkFetching("redir");
  endtask

  task automatic resetMain();
    rst_n = 1'b0;
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    expPc     = 32'h0;
    lastPc    = 32'h0;
    lastInstr = 32'h0;
    expErr    = 1'b0;
    checkOutput("rst.req",   32'(imem_req), 32'd0);
    checkOutput("rst.valid", 32'(if_valid), 32'd0);
    checkOutput("rst.instr", if_instr, 32'h0);
    checkOutput("rst.ifpc",  if_pc, 32'h0);
    checkOutput("rst.err",   32'(fetch_err), 32'd0);
    checkOutput("rst.addr",  imem_addr, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    rst2N = 1'b0; ack2 = 1'b0; rdata2 = '0; stall2 = 1'b0;
    redirValid2 = 1'b0; redirPc2 = '0;

    resetMain();
    rst2N = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkFetching("firstReq");

    doFetch(1, 32'h0050_0093, 0, 1'b0);
    doFetch(1, 32'h0050_0093, 0, 1'b0);
    doFetch(1, 32'h0050_0093, 0, 1'b0);
    checkOutput("seq.lastpc", lastPc, 32'h8);
    doFetch(1, 32'h0050_0093, 5, 1'b0);

    doRedirect(1, 1'b0, 32'h0000_0100);
    doFetch(1, 32'h0000_00B3, 0, 1'b0);
    checkOutput("redir.pc", lastPc, 32'h100);
    checkOutput("redir.op", 32'(lastInstr[6:0]), 32'(7'b0110011));

    doRedirect(0, 1'b1, 32'h0000_0040);
    doRedirect(1, 1'b0, 32'h0000_0102);
    doFetch(0, $urandom, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        doRedirect($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
      end else begin
        doFetch($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                $urandom_range(0, 7) == 0);
      end
    end

    resetMain();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    expPc = 32'h200;
    checkFetching("idleRedir");
    doFetch(0, $urandom, 0, 1'b0);

    checkOutput("wrap.req",  32'(req2), 32'd1);
    checkOutput("wrap.addr", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1; rdata2 = 32'h0050_0093;
    step();
    ack2 = 1'b0;
    checkOutput("wrap.valid", 32'(valid2), 32'd1);
    checkOutput("wrap.ifpc",  ifPc2, 32'hFFFF_FFFC);
    step();
    checkOutput("wrap.next",  addr2, 32'h0);
    checkOutput("wrap.req2",  32'(req2), 32'd1);
    ack2 = 1'b1; rst2N = 1'b0;
    step();
    checkOutput("wrap.rstValid", 32'(valid2), 32'd0);
    checkOutput("wrap.rstReq",   32'(req2), 32'd0);
    checkOutput("wrap.rstAddr",  addr2, 32'hFFFF_FFFC);
    checkOutput("wrap.rstIfPc",  ifPc2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
